// File: rtl/bram_snap_sp_pkg.sv
// Shared types for the snapshot capture buffer: controller state encoding
// and a small decode helper used by the top and the interface.
package bram_snap_sp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } snap_state_t;

  // True while the BRAM port belongs to the capture side.
  function automatic logic is_write_phase(snap_state_t s);
    return (s == ST_ARMED) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/bram_snap_sp_if.sv
// Stream-in / readback-out bundle of the snapshot buffer.
//
// Handshake semantics (no backpressure anywhere):
//   din_valid qualifies din in the same cycle; the buffer always accepts it.
//   rd_en + rd_addr is a read request; the answer appears as rd_valid=1 with
//   rd_data exactly one cycle later. Requests outside DONE are dropped.
interface bram_snap_sp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  import bram_snap_sp_pkg::*;

  logic                  arm;
  logic                  abort;
  logic                  trigger;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  armed;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   count;
  snap_state_t           state;

  modport master (
    output arm, abort, trigger, din, din_valid, rd_en, rd_addr,
    input  rd_data, rd_valid, armed, busy, done, count, state
  );

  modport slave (
    input  arm, abort, trigger, din, din_valid, rd_en, rd_addr,
    output rd_data, rd_valid, armed, busy, done, count, state
  );

endinterface

// File: rtl/bram_snap_sp_bram.sv
// Single-port synchronous RAM, read-first, one cycle read latency.
// rst only clears the output register; the array itself is never cleared.
module bram_sync_sp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Array write, kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= data_in;
  end

  // Registered read port (old data on a same-address write).
  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else     data_out <= mem[addr];
  end

endmodule

// File: rtl/bram_snap_sp.sv
// Snapshot capture buffer: arm, wait for a qualified trigger, store DEPTH
// consecutive valid words into one single-port BRAM, then serve random reads.
// The BRAM port is time-shared: capture side in ARMED/CAPTURE, reads otherwise.
module bram_snap_sp
  import bram_snap_sp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  bram_snap_sp_if.slave bus
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  snap_state_t           state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_valid;

  logic                  wr_qual;
  logic                  bram_wr;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_dout;

  // Which stream words get stored: the triggering word in ARMED, any valid word in CAPTURE.
  always_comb begin
    wr_qual = 1'b0;
    case (state)
      ST_ARMED:   wr_qual = bus.trigger & bus.din_valid;
      ST_CAPTURE: wr_qual = bus.din_valid;
      default:    wr_qual = 1'b0;
    endcase
  end

  // BRAM port mux: write pointer while capturing, read address otherwise.
  always_comb begin
    bram_addr = bus.rd_addr;
    bram_wr   = 1'b0;
    if (is_write_phase(state)) begin
      bram_addr = wr_ptr;
      bram_wr   = wr_qual;
    end
  end

  bram_sync_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk      (clk),
    .rst      (1'b0),
    .wr       (bram_wr),
    .addr     (bram_addr),
    .data_in  (bus.din),
    .data_out (bram_dout)
  );

  // Controller: state, write pointer, word count and read strobe.
  // abort wins over everything; a write already qualified this cycle still lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (bus.abort) begin
        state  <= ST_IDLE;
        wr_ptr <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.arm) begin
              state  <= ST_ARMED;
              count  <= '0;
              wr_ptr <= '0;
            end
          end
          ST_ARMED: begin
            if (wr_qual) begin
              state  <= ST_CAPTURE;
              wr_ptr <= PTR_ONE;
              count  <= CNT_ONE;
            end
          end
          ST_CAPTURE: begin
            if (wr_qual) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              count  <= count + CNT_ONE;
              if (wr_ptr == LAST_ADDR) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (bus.arm) begin
              state  <= ST_ARMED;
              count  <= '0;
              wr_ptr <= '0;
            end else if (bus.rd_en) begin
              rd_valid <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.state    = state;
  assign bus.armed    = (state == ST_ARMED);
  assign bus.busy     = is_write_phase(state);
  assign bus.done     = (state == ST_DONE);
  assign bus.count    = count;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = bram_dout;

endmodule

// File: tb/tb_bram_snap_sp.sv
// Bench for bram_snap_sp: scenario tasks with inline checks, a reference
// memory image built from the driven stream, and a queue of expected read data.
module tb_bram_snap_sp;
  import bram_snap_sp_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_snap_sp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_snap_sp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arm       = 1'b0;
    bus.abort     = 1'b0;
    bus.trigger   = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
  endtask

  task automatic pulse_arm(input string tag);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    vec_cnt++;
    if (bus.armed !== 1'b1 || bus.busy !== 1'b1 || bus.count !== 5'd0) begin
      err_cnt++;
      $display("FAIL %s arm: armed=%b busy=%b count=%0d, want 1 1 0", tag, bus.armed, bus.busy, bus.count);
    end
  endtask

  // Continuous 16-word capture of base+i, trigger on the first word.
  task automatic capture_linear(input logic [DW-1:0] base, input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.din       = base + DW'(i);
      bus.din_valid = 1'b1;
      bus.trigger   = (i == 0);
      model_mem[i]  = base + DW'(i);
      step();
      vec_cnt++;
      if (bus.count !== 5'(i + 1) || bus.rd_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s word %0d: count=%0d rd_valid=%b, want %0d 0", tag, i, bus.count, bus.rd_valid, i + 1);
      end
    end
    bus.din_valid = 1'b0;
    bus.trigger   = 1'b0;
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 5'd16) begin
      err_cnt++;
      $display("FAIL %s end: done=%b busy=%b count=%0d, want 1 0 16", tag, bus.done, bus.busy, bus.count);
    end
  endtask

  // Back-to-back reads of all addresses, compared against the queue.
  task automatic read_all(input string tag);
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(i);
      exp_q.push_back(model_mem[i]);
      step();
      exp = exp_q.pop_front();
      vec_cnt++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
        err_cnt++;
        $display("FAIL %s read addr %0d: rd_valid=%b rd_data=%h, want 1 %h", tag, i, bus.rd_valid, bus.rd_data, exp);
      end
    end
    bus.rd_en = 1'b0;
    step();
    vec_cnt++;
    if (bus.rd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s read idle: rd_valid=%b want 0", tag, bus.rd_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.arm     = i[0];
      bus.trigger = ~i[0];
      bus.din_valid = 1'b1;
      step();
    end
    vec_cnt++;
    if (bus.armed !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL reset: armed=%b busy=%b done=%b count=%0d rd_valid=%b, want all 0",
               bus.armed, bus.busy, bus.done, bus.count, bus.rd_valid);
    end
    idle_inputs();
    rst = 1'b1;
    step();
    vec_cnt++;
    if (bus.state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL reset release: state=%0d want IDLE", bus.state);
    end
  endtask

  task automatic test_basic();
    pulse_arm("basic");
    capture_linear(8'h10, "basic");
    read_all("basic");
  endtask

  task automatic test_trigger_qualify();
    pulse_arm("trig");
    bus.trigger   = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = 8'h5A;
    repeat (3) step();
    vec_cnt++;
    if (bus.armed !== 1'b1 || bus.count !== 5'd0) begin
      err_cnt++;
      $display("FAIL trig no-valid: armed=%b count=%0d, want 1 0", bus.armed, bus.count);
    end
    bus.din       = 8'hA5;
    bus.din_valid = 1'b1;
    model_mem[0]  = 8'hA5;
    step();
    vec_cnt++;
    if (bus.count !== 5'd1 || bus.state !== ST_CAPTURE) begin
      err_cnt++;
      $display("FAIL trig first word: count=%0d state=%0d, want 1 CAPTURE", bus.count, bus.state);
    end
    for (int i = 1; i < DEPTH; i++) begin
      bus.din      = DW'($urandom_range(0, 255));
      bus.trigger  = 1'($urandom_range(0, 1));
      model_mem[i] = bus.din;
      step();
    end
    bus.din_valid = 1'b0;
    bus.trigger   = 1'b0;
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.count !== 5'd16) begin
      err_cnt++;
      $display("FAIL trig end: done=%b count=%0d, want 1 16", bus.done, bus.count);
    end
    read_all("trig");
  endtask

  task automatic test_gapped();
    int written;
    written = 0;
    pulse_arm("gap");
    for (int cyc = 0; cyc < 40 && written < DEPTH; cyc++) begin
      bus.din_valid = (cyc % 2 == 0);
      bus.trigger   = (cyc == 0);
      bus.din       = DW'($urandom_range(0, 255));
      if (bus.din_valid) begin
        model_mem[written] = bus.din;
        written++;
      end
      step();
      vec_cnt++;
      if (bus.count !== 5'(written)) begin
        err_cnt++;
        $display("FAIL gap cycle %0d: count=%0d want %0d", cyc, bus.count, written);
      end
    end
    bus.din_valid = 1'b0;
    bus.trigger   = 1'b0;
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.count !== 5'd16) begin
      err_cnt++;
      $display("FAIL gap end: done=%b count=%0d, want 1 16", bus.done, bus.count);
    end
    read_all("gap");
  endtask

  task automatic test_abort();
    pulse_arm("abort");
    for (int i = 0; i < 7; i++) begin
      bus.din       = 8'h40 + DW'(i);
      bus.din_valid = 1'b1;
      bus.trigger   = (i == 0);
      step();
    end
    bus.din_valid = 1'b0;
    bus.trigger   = 1'b0;
    bus.abort     = 1'b1;
    bus.arm       = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.arm   = 1'b0;
    vec_cnt++;
    if (bus.state !== ST_IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 5'd7) begin
      err_cnt++;
      $display("FAIL abort: state=%0d busy=%b done=%b count=%0d, want IDLE 0 0 7",
               bus.state, bus.busy, bus.done, bus.count);
    end
    pulse_arm("abort rearm");
    capture_linear(8'h80, "abort rearm");
    read_all("abort rearm");
    // Reset in the middle of a capture.
    pulse_arm("rstmid");
    for (int i = 0; i < 5; i++) begin
      bus.din       = 8'hE0 + DW'(i);
      bus.din_valid = 1'b1;
      bus.trigger   = (i == 0);
      step();
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 5'd0 || bus.state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL reset mid-capture: busy=%b done=%b count=%0d, want 0 0 0", bus.busy, bus.done, bus.count);
    end
    idle_inputs();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_read_gating();
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd5;
    step();
    vec_cnt++;
    if (bus.rd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL gating idle: rd_valid=%b want 0", bus.rd_valid);
    end
    pulse_arm("gating");
    step();
    vec_cnt++;
    if (bus.rd_valid !== 1'b0 || bus.armed !== 1'b1) begin
      err_cnt++;
      $display("FAIL gating armed: rd_valid=%b armed=%b, want 0 1", bus.rd_valid, bus.armed);
    end
    bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
    capture_linear(8'hC0, "gating");
    bus.rd_en = 1'b0;
    read_all("gating");
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd3;
    bus.arm     = 1'b1;
    step();
    bus.arm   = 1'b0;
    bus.rd_en = 1'b0;
    vec_cnt++;
    if (bus.armed !== 1'b1 || bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
      err_cnt++;
      $display("FAIL gating rearm: armed=%b rd_valid=%b count=%0d, want 1 0 0", bus.armed, bus.rd_valid, bus.count);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    vec_cnt++;
    if (bus.state !== ST_IDLE || bus.armed !== 1'b0) begin
      err_cnt++;
      $display("FAIL gating abort: state=%0d armed=%b, want IDLE 0", bus.state, bus.armed);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_trigger_qualify();
    test_gapped();
    test_abort();
    test_read_gating();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
